// File: rtl/sram_pixel_port_pkg.sv
// Shared definitions for the warp-path SRAM pixel port and its neighbours
// (image geometry, SRAM widths, RGB565 layout, slot types).
package sram_pixel_port_pkg;

    localparam int IMG_W_DEF = 320;
    localparam int IMG_H_DEF = 240;
    localparam int SRAM_AW   = 18;
    localparam int SRAM_DW   = 16;
    localparam int COORD_W   = 10;

    localparam int R_HI = 15;
    localparam int R_LO = 11;
    localparam int G_HI = 10;
    localparam int G_LO = 5;
    localparam int B_HI = 4;
    localparam int B_LO = 0;

    typedef enum logic [1:0] {
        SLOT_IDLE  = 2'd0,
        SLOT_READ  = 2'd1,
        SLOT_WRITE = 2'd2
    } slot_e;

    typedef struct packed {
        logic [SRAM_AW-1:0] addr;
        logic [SRAM_DW-1:0] data;
    } wentry_t;

    // Raster address in SRAM word units; 18 bits covers any frame that fits the part.
    function automatic logic [SRAM_AW-1:0] pix_addr(input logic [COORD_W-1:0] x,
                                                    input logic [COORD_W-1:0] y,
                                                    input int w);
        return SRAM_AW'(y) * SRAM_AW'(w) + SRAM_AW'(x);
    endfunction

endpackage

// File: rtl/pixel_wfifo.sv
// Small synchronous FIFO buffering capture writes until the SRAM has a free slot.
module pixel_wfifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, rp_q;
    logic [AW:0]      cnt_q, cnt_d;
    logic             full_q;
    logic             do_push, do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop)
            cnt_d = cnt_q + 1'b1;
        else if (!do_push && do_pop)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wp_q   <= '0;
            rp_q   <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            if (do_push) wp_q <= wp_q + 1'b1;
            if (do_pop)  rp_q <= rp_q + 1'b1;
            cnt_q  <= cnt_d;
            full_q <= (cnt_d == (AW+1)'(DEPTH));
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wp_q] <= data_i;
    end

    assign data_o  = mem_q[rp_q];
    assign full_o  = full_q;
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/sram_pixel_port.sv
// SRAM front end: one-cycle pixel reads for the homography stage, with capture
// writes buffered and retired into slots the reader leaves free.
module sram_pixel_port
    import sram_pixel_port_pkg::*;
#(
    parameter int IMG_W       = IMG_W_DEF,
    parameter int IMG_H       = IMG_H_DEF,
    parameter int WFIFO_DEPTH = 4
) (
    input  logic                iCLK,
    input  logic                iRST_N,
    input  logic                iREQ,
    input  logic [COORD_W-1:0]  iX,
    input  logic [COORD_W-1:0]  iY,
    output logic                oREADY,
    output logic [4:0]          oR,
    output logic [5:0]          oG,
    output logic [4:0]          oB,
    input  logic                iW_REQ,
    input  logic [COORD_W-1:0]  iW_X,
    input  logic [COORD_W-1:0]  iW_Y,
    input  logic [SRAM_DW-1:0]  iW_DATA,
    output logic                oW_FULL,
    output logic [SRAM_AW-1:0]  oSRAM_ADDR,
    inout  wire  [SRAM_DW-1:0]  SRAM_DQ,
    output logic                oSRAM_CE_N,
    output logic                oSRAM_OE_N,
    output logic                oSRAM_WE_N,
    output logic                oSRAM_UB_N,
    output logic                oSRAM_LB_N
);

    localparam int CW = $clog2(WFIFO_DEPTH) + 1;

    logic          rd_hit, w_inr, w_push, w_pop, w_full, w_empty;
    logic [CW-1:0] w_cnt;
    wentry_t       w_in, w_head;

    slot_e               slot_q, slot_d;
    logic                rdy_q, rdy_d;
    logic [SRAM_AW-1:0]  addr_q, addr_d;
    logic [SRAM_DW-1:0]  wdata_q, wdata_d;
    logic                ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic                dq_oe_q, dq_oe_d;

    assign rd_hit = iREQ   && (32'(iX)   < IMG_W) && (32'(iY)   < IMG_H);
    assign w_inr  = iW_REQ && (32'(iW_X) < IMG_W) && (32'(iW_Y) < IMG_H);
    assign w_push = w_inr && (32'(w_cnt) < WFIFO_DEPTH);
    assign w_pop  = !rd_hit && !w_empty;

    assign w_in.addr = pix_addr(iW_X, iW_Y, IMG_W);
    assign w_in.data = iW_DATA;

    pixel_wfifo #(
        .WIDTH ($bits(wentry_t)),
        .DEPTH (WFIFO_DEPTH)
    ) u_wfifo (
        .clk_i   (iCLK),
        .rst_ni  (iRST_N),
        .push_i  (w_push),
        .data_i  (w_in),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_cnt)
    );

    // Slot scheduler: reads always win; a write only takes a slot no read claimed.
    always_comb begin
        slot_d  = SLOT_IDLE;
        rdy_d   = iREQ;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (rd_hit) begin
            slot_d = SLOT_READ;
            addr_d = pix_addr(iX, iY, IMG_W);
        end else if (!w_empty) begin
            slot_d  = SLOT_WRITE;
            addr_d  = w_head.addr;
            wdata_d = w_head.data;
        end
        ce_n_d  = (slot_d == SLOT_IDLE);
        oe_n_d  = (slot_d != SLOT_READ);
        we_n_d  = (slot_d != SLOT_WRITE);
        dq_oe_d = (slot_d == SLOT_WRITE);
    end

    // Strobes and bus enable share one register stage with the slot type,
    // so READ/WRITE transitions cannot glitch the bus direction.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            slot_q  <= SLOT_IDLE;
            rdy_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            rdy_q   <= rdy_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            dq_oe_q <= dq_oe_d;
        end
    end

    // Read data is taken straight from the pins; out-of-range reads return zero.
    always_comb begin
        oR = '0;
        oG = '0;
        oB = '0;
        if (rdy_q && slot_q == SLOT_READ) begin
            oR = SRAM_DQ[R_HI:R_LO];
            oG = SRAM_DQ[G_HI:G_LO];
            oB = SRAM_DQ[B_HI:B_LO];
        end
    end

    assign SRAM_DQ    = dq_oe_q ? wdata_q : {SRAM_DW{1'bz}};
    assign oREADY     = rdy_q;
    assign oW_FULL    = w_full;
    assign oSRAM_ADDR = addr_q;
    assign oSRAM_CE_N = ce_n_q;
    assign oSRAM_OE_N = oe_n_q;
    assign oSRAM_WE_N = we_n_q;
    assign oSRAM_UB_N = ce_n_q;
    assign oSRAM_LB_N = ce_n_q;

endmodule

// File: tb/tb_sram_pixel_port.sv
// Scoreboard bench for sram_pixel_port with a behavioural async SRAM on the pins.
module tb_sram_pixel_port;
  import sram_pixel_port_pkg::*;

  localparam int W = 320;
  localparam int H = 240;
  localparam int D = 4;

  logic        iCLK = 1'b0, iRST_N = 1'b0;
  logic        iREQ = 1'b0, iW_REQ = 1'b0;
  logic [9:0]  iX = '0, iY = '0, iW_X = '0, iW_Y = '0;
  logic [15:0] iW_DATA = '0;
  logic        oREADY, oW_FULL;
  logic [4:0]  oR, oB;
  logic [5:0]  oG;
  logic [17:0] oSRAM_ADDR;
  logic        oSRAM_CE_N, oSRAM_OE_N, oSRAM_WE_N, oSRAM_UB_N, oSRAM_LB_N;
  wire  [15:0] SRAM_DQ;

  always #5 iCLK = ~iCLK;

  sram_pixel_port #(.IMG_W(W), .IMG_H(H), .WFIFO_DEPTH(D)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iREQ(iREQ), .iX(iX), .iY(iY),
    .oREADY(oREADY), .oR(oR), .oG(oG), .oB(oB),
    .iW_REQ(iW_REQ), .iW_X(iW_X), .iW_Y(iW_Y), .iW_DATA(iW_DATA), .oW_FULL(oW_FULL),
    .oSRAM_ADDR(oSRAM_ADDR), .SRAM_DQ(SRAM_DQ),
    .oSRAM_CE_N(oSRAM_CE_N), .oSRAM_OE_N(oSRAM_OE_N), .oSRAM_WE_N(oSRAM_WE_N),
    .oSRAM_UB_N(oSRAM_UB_N), .oSRAM_LB_N(oSRAM_LB_N)
  );

  logic [15:0] sram    [0:262143];
  logic [15:0] ref_mem [0:262143];

  assign SRAM_DQ = (!oSRAM_CE_N && !oSRAM_OE_N && oSRAM_WE_N) ? sram[oSRAM_ADDR] : 16'hzzzz;

  typedef struct {
    logic        rdy;
    logic        inr;
    logic [15:0] pix;
    logic [17:0] addr;
  } rexp_t;

  rexp_t       rq[$];
  logic [33:0] wq[$];
  int n_chk = 0, n_err = 0;
  int n_push = 0, n_pop = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  rexp_t       me;
  logic [33:0] mw;
  always @(negedge iCLK) begin
    if (iRST_N) begin
      if (rq.size() > 0) begin
        me = rq.pop_front();
        chk("rd_rdy", 32'(oREADY), 32'(me.rdy));
        chk("rd_pix", 32'({oR, oG, oB}), 32'(me.pix));
        if (me.inr) begin
          chk("rd_addr", 32'(oSRAM_ADDR), 32'(me.addr));
          chk("rd_strb", 32'({oSRAM_CE_N, oSRAM_OE_N, oSRAM_WE_N}), 32'b001);
        end
      end
      if (!oSRAM_WE_N) begin
        sram[oSRAM_ADDR] = SRAM_DQ;
        chk("wr_pending", 32'(wq.size() > 0), 32'd1);
        if (wq.size() > 0) begin
          mw = wq.pop_front();
          chk("wr_addr", 32'(oSRAM_ADDR), 32'(mw[33:16]));
          chk("wr_data", 32'(SRAM_DQ), 32'(mw[15:0]));
          chk("wr_strb", 32'({oSRAM_CE_N, oSRAM_OE_N, oSRAM_UB_N, oSRAM_LB_N}), 32'b0100);
          n_pop++;
        end
      end
    end
  end

  // One clock: drive inputs, record expectations, return at negedge + 1.
  task automatic cyc(input bit req, input int x, input int y,
                     input bit wreq, input int wx, input int wy, input logic [15:0] wd);
    rexp_t e;
    logic [17:0] wa;
    iREQ = req; iX = 10'(x); iY = 10'(y);
    iW_REQ = wreq; iW_X = 10'(wx); iW_Y = 10'(wy); iW_DATA = wd;
    e.rdy  = req;
    e.inr  = req && x < W && y < H;
    e.addr = e.inr ? 18'(y * W + x) : 18'd0;
    e.pix  = e.inr ? ref_mem[e.addr] : 16'd0;
    rq.push_back(e);
    if (wreq && wx < W && wy < H && (n_push - n_pop) < D) begin
      wa = 18'(wy * W + wx);
      wq.push_back({wa, wd});
      ref_mem[wa] = wd;
      n_push++;
    end
    @(negedge iCLK); #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 16'h0);
  endtask

  logic [15:0] v;
  initial begin
    sram[965] = 16'hF81F; ref_mem[965] = 16'hF81F;
    for (int k = 0; k < 10; k++) begin
      v = 16'h1234 + 16'(k) * 16'h0911;
      sram[5*W+k] = v; ref_mem[5*W+k] = v;
    end

    repeat (3) begin @(negedge iCLK); #1; end
    chk("rst_rdy", 32'(oREADY), 0);
    chk("rst_rgb", 32'({oR, oG, oB}), 0);
    chk("rst_full", 32'(oW_FULL), 0);
    chk("rst_addr", 32'(oSRAM_ADDR), 0);
    chk("rst_strb", 32'({oSRAM_CE_N, oSRAM_OE_N, oSRAM_WE_N, oSRAM_UB_N, oSRAM_LB_N}), 32'h1f);
    iRST_N = 1'b1;

    // Single read
    cyc(1, 5, 3, 0, 0, 0, 16'h0);
    chk("sr_r", 32'(oR), 31); chk("sr_g", 32'(oG), 0); chk("sr_b", 32'(oB), 31);
    chk("sr_addr", 32'(oSRAM_ADDR), 965);
    idle();
    chk("idle_rdy", 32'(oREADY), 0);

    // Out-of-range reads
    cyc(1, 320, 0, 0, 0, 0, 16'h0);
    chk("oor_ce", 32'(oSRAM_CE_N), 1);
    cyc(1, 0, 240, 0, 0, 0, 16'h0);
    chk("oor_ce_y", 32'(oSRAM_CE_N), 1);

    // Writes starved by continuous reads; fifth write hits a full FIFO
    for (int k = 0; k < 8; k++) begin
      cyc(1, k, 5, k < 5, 20 + k, 7, 16'hA000 + 16'(k));
      chk("starve_full", 32'(oW_FULL), 32'((n_push - n_pop) == D));
    end
    chk("starve_cnt", 32'(n_push - n_pop), D);
    for (int k = 0; k < 4; k++) begin
      idle();
      chk("drain_we", 32'(oSRAM_WE_N), 0);
    end
    idle();
    chk("drained_we", 32'(oSRAM_WE_N), 1);
    chk("drained_full", 32'(oW_FULL), 0);

    // Read-after-write
    cyc(0, 0, 0, 1, 10, 10, 16'h07E0);
    idle();
    cyc(1, 10, 10, 0, 0, 0, 16'h0);
    chk("raw_g", 32'(oG), 63); chk("raw_r", 32'(oR), 0); chk("raw_b", 32'(oB), 0);

    // Interleave reads with pending writes
    for (int k = 0; k < 3; k++) cyc(1, k, 5, 1, 30 + k, 8, 16'hB000 + 16'(3 * k));
    for (int k = 0; k < 6; k++) begin
      cyc(k % 2 == 0, k, 5, 0, 0, 0, 16'h0);
      if (k % 2 == 1) chk("il_we", 32'(oSRAM_WE_N), 0);
      else            chk("il_oe", 32'({oSRAM_OE_N, oSRAM_WE_N}), 32'b01);
    end
    idle();
    chk("il_done", 32'(oSRAM_WE_N), 1);

    // Reset in the middle of a write burst
    cyc(1, 0, 5, 1, 40, 9, 16'hC001);
    cyc(1, 1, 5, 1, 41, 9, 16'hC002);
    idle();
    chk("mid_we", 32'(oSRAM_WE_N), 0);
    iRST_N = 1'b0;
    #1;
    chk("mr_strb", 32'({oSRAM_CE_N, oSRAM_OE_N, oSRAM_WE_N, oSRAM_UB_N, oSRAM_LB_N}), 32'h1f);
    chk("mr_rdy", 32'(oREADY), 0);
    chk("mr_full", 32'(oW_FULL), 0);
    wq.delete(); rq.delete(); n_push = n_pop;
    repeat (2) begin @(negedge iCLK); #1; end
    iRST_N = 1'b1;
    for (int k = 0; k < 3; k++) begin
      idle();
      chk("mr_nowr", 32'(oSRAM_WE_N), 1);
    end
    cyc(1, 5, 3, 0, 0, 0, 16'h0);
    chk("mr_read", 32'(oR), 31);

    chk("rq_empty", 32'(rq.size()), 0);
    chk("wq_empty", 32'(wq.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sram_pixel_port.md
# sram_pixel_port

Single-port SRAM front end for the warp path. It serves per-pixel read requests from the homography stage with a fixed one-cycle latency and returns RGB565 data split into R/G/B fields. It also accepts frame-capture pixel writes, buffers them in a small FIFO, and retires them into the SRAM only on cycles with no read. It sits between the homography stage's SRAM-side handshake and the board's 256K×16 asynchronous SRAM.

## Interface
- IMG_W, 320, image width in pixels; address = Y*IMG_W + X
- IMG_H, 240, image height in pixels
- WFIFO_DEPTH, 4, write-buffer depth in entries (power of two)

Ports (one clock; reset is asynchronous and active-low):
- iCLK  in  1  system clock
- iRST_N  in  1  asynchronous active-low reset
- iREQ  in  1  read request; sampled every edge
- iX, iY  in  10 each  read coordinate; valid with iREQ
- oREADY  out  1  read data valid
- oR / oG / oB  out  5 / 6 / 5  read pixel fields
- iW_REQ  in  1  write request
- iW_X, iW_Y  in  10 each  write coordinate
- iW_DATA  in  16  RGB565 pixel: R=[15:11], G=[10:5], B=[4:0]
- oW_FULL  out  1  write FIFO full; writes are ignored while high
- oSRAM_ADDR  out  18  SRAM word address
- SRAM_DQ  inout  16  SRAM data bus
- oSRAM_CE_N, oSRAM_OE_N, oSRAM_WE_N, oSRAM_UB_N, oSRAM_LB_N  out  1 each  SRAM strobes, active-low

## Operation
- Each cycle is one slot: IDLE, READ or WRITE. The slot type is registered from the previous edge.
- **Read slot selection:** iREQ high with in-range X < IMG_W and Y < IMG_H at edge n gives a READ slot in cycle n+1.
  - oSRAM_ADDR = Y*IMG_W+X, computed in 18 bits and registered.
  - CE_N, OE_N, UB_N and LB_N are low; WE_N is high; DQ is high-Z.
- **Read return:** in a READ slot, oREADY = 1 and oR/oG/oB = SRAM_DQ[15:11]/[10:5]/[4:0]. This path is combinational from the pins.
- **Out-of-range read:** iREQ with X ≥ IMG_W or Y ≥ IMG_H gives oREADY = 1 in cycle n+1 with RGB = 0. No SRAM access is made, so the slot is free for a write.
- **Idle outputs:** whenever oREADY = 0, oR/oG/oB = 0.
- **Write enqueue:** iW_REQ at an edge with oW_FULL = 0 and in-range coordinates pushes {address, iW_DATA}.
  - Out-of-range writes are silently dropped.
  - iW_REQ while oW_FULL = 1 is ignored; the producer must hold and retry.
- **Write retire:** if the FIFO is non-empty at edge n and no READ slot is scheduled for n+1, the head is popped and cycle n+1 is a WRITE slot.
  - oSRAM_ADDR = entry address; CE_N, WE_N, UB_N and LB_N are low; OE_N is high; DQ is driven with the entry data.
- **Priority:** a read always beats a pending write, so back-to-back reads starve writes indefinitely. The downstream scan guarantees gaps.
- **Simultaneous push and pop:** allowed; the count is unchanged. A push on the same edge the FIFO becomes non-full is accepted only if oW_FULL was 0 at that edge.
- **Reset mid-operation:** the FIFO is flushed, any in-flight write is lost, and the bus is released within the reset assertion.

## Timing
- **Reset values:** oREADY = 0, oR/oG/oB = 0, oW_FULL = 0, oSRAM_ADDR = 0, all strobes = 1, DQ high-Z, FIFO count = 0.
- **Read latency:** exactly 1 cycle, from iREQ at edge n to oREADY in cycle n+1.
  - This matches the homography stage, which captures data one cycle after raising its request.
- **Read throughput:** one read per cycle, sustained.
- **Write latency:** from enqueue to the WRITE slot is at least 1 cycle and unbounded under read pressure.
- **oW_FULL:** registered; equals (count == WFIFO_DEPTH) after each edge.
- **Bus turnaround:** DQ is driven only in WRITE slots. The output enable is registered together with the slot type, so there is no glitch between adjacent READ and WRITE slots.

## Structure
- **Shared package:** IMG_W and IMG_H defaults, SRAM_AW = 18, the RGB565 field bit positions, and a slot-type enum {IDLE, READ, WRITE}. The homography and capture blocks use the same package.
- **Sub-module:** pixel_wfifo, a synchronous FIFO of width 34 (18-bit address + 16-bit data) and depth WFIFO_DEPTH, with push, pop, full, empty and count.
- **Top level:** the address multiplier (constant IMG_W), slot scheduler, strobe registers and DQ tristate.

## Test plan
- **Reset:** assert iRST_N = 0 mid-write → all strobes 1, DQ high-Z, oREADY = 0, FIFO empty after release.
- **Single read:** preload addr 3*320+5 with 16'hF81F; iREQ with X = 5, Y = 3 → next cycle oREADY = 1, oR = 31, oG = 0, oB = 31, oSRAM_ADDR = 965.
- **Out-of-range read:** iREQ with X = 320, Y = 0 → next cycle oREADY = 1, RGB = 0, CE_N = 1.
- **Write starvation and FIFO limits:**
  - 5 consecutive writes during continuous reads → oW_FULL = 1 after the 4th and the 5th is ignored.
  - Stop the reads → 4 WRITE slots in successive cycles, in order, then FIFO empty.
- **Read-after-write:** write 16'h07E0 to (10,10), idle one cycle, then read (10,10) → oG = 63, oR = oB = 0.
- **Interleave:** alternate iREQ on/off with the FIFO non-empty → READ and WRITE slots alternate, and DQ is never driven during a READ slot.
